instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//  Owns the architectural PC register and fetches one instruction per step from
//  instruction memory over a req/ack handshake, then presents it to decode with valid/ready.
//  Sits upstream of the combinational next-PC logic: drives pc_now and the fetched opcode
//  to it, and loads its pc_next result when decode accepts the instruction.
//  Non-pipelined: the next fetch starts only after the current instruction retires.
// PARAMETERS
//  PC_W      8      PC / instruction-memory address width
//  INSTR_W   16     instruction word width; opcode = instr[INSTR_W-1 -: 4]
//  RESET_PC  8'h00  PC value after reset
//  TIMEOUT   15     imem wait cycles without ack before retry (1..255)
//  HALT_OP   4'h0   opcode that halts fetch
// PORTS
//  clk          in   1        system clock, rising edge
//  rst_n        in   1        asynchronous active-low reset
//  pc_next      in   PC_W     next PC from next-PC logic; sampled on accept
//  pc_now       out  PC_W     current PC register, to next-PC logic and debug
//  imem_req     out  1        fetch request, held until imem_ack
//  imem_addr    out  PC_W     fetch address (= pc_now), stable while imem_req=1
//  imem_ack     in   1        memory has data on imem_rdata this cycle
//  imem_rdata   in   INSTR_W  instruction word, valid when imem_ack=1
//  instr_valid  out  1        instr holds a fetched, un-accepted instruction
//  instr        out  INSTR_W  instruction to decode; stable while instr_valid=1
//  instr_ready  in   1        decode accepts (instruction retires) this cycle
//  halted       out  1        HALT_OP instruction retired; sticky until reset
//  fetch_err    out  1        sticky: at least one imem timeout occurred
// BEHAVIOUR
//  Reset (async assert, sync release): pc_now=RESET_PC, state=REQ, imem_req=0 during reset,
//   instr_valid=0, instr=0, halted=0, fetch_err=0, wait counter=0.
//  All outputs are registered or decoded from the state register only (no comb in->out path).
//  States: REQ, RETRY, ISSUE, HALTED.
//   REQ:    imem_req=1, imem_addr=pc_now. First REQ cycle is the first clk after rst_n release.
//           imem_ack=1 -> instr<=imem_rdata, -> ISSUE (instr_valid=1 the next cycle; 1-cycle latency).
//           no ack -> wait counter +1; counter==TIMEOUT-1 with no ack -> fetch_err<=1,
//           counter<=0, -> RETRY.
//   RETRY:  imem_req=0 for exactly one cycle, ack ignored, -> REQ (same address).
//   ISSUE:  instr_valid=1, imem_req=0. instr_ready=0 -> hold instr, pc unchanged.
//           instr_ready=1 -> pc_now<=pc_next (same cycle's value); opcode==HALT_OP -> HALTED,
//           else -> REQ. instr_valid drops the cycle after accept.
//   HALTED: halted=1, imem_req=0, instr_valid=0, pc held; leaves only via reset.
//  Wait counter resets to 0 on ack and on leaving REQ.
//  imem_ack outside REQ is ignored (no capture, no state change).
//  PC wrap-around: none here; pc_next is loaded as-is (0xFF->0x00 produced upstream).
//  Ack on the same cycle counter hits TIMEOUT-1: ack wins, no error, -> ISSUE.
//  Reset mid-fetch or mid-issue: pending request/instruction discarded, reset values restored.
// STRUCTURE
//  cpu_pkg: opcode constants (OP_HALT=4'b0000, OP_JMP=4'b0101, OP_BEQ=4'b0110),
//   fetch_state_t enum {REQ, RETRY, ISSUE, HALTED}, PC_W/INSTR_W defaults.
//  Sub-module fetch_timeout_ctr: clear/enable counter, terminal-count pulse at TIMEOUT-1.
//  FSM, PC register and instruction register stay in instr_fetch_unit.
// TESTING
//  1 Reset release, memory acks every request after 1 cycle, ready=1: imem_addr 0x00 then
//    pc_next-driven sequence 0x01,0x02,...; instr_valid 1 cycle after each ack.
//  2 Back-pressure: instr=16'h1234 valid, instr_ready low 5 cycles -> instr/pc_now stable,
//    imem_req=0; ready high -> pc_now<=pc_next, next req at new address.
//  3 Jump: instr opcode 0101, pc_next=0x40 on accept -> next imem_addr=0x40.
//  4 Timeout: no ack for TIMEOUT cycles at addr 0x07 -> fetch_err=1, 1 cycle req=0, req
//    reasserted at 0x07; ack then -> normal fetch, fetch_err stays 1.
//  5 Halt: instr 16'h0000 accepted -> halted=1 next cycle, imem_req stays 0 for 20 cycles
//    and pc_now unchanged; ack pulses ignored.
//  6 rst_n asserted during REQ and during ISSUE -> all outputs at reset values immediately,
//    fetch restarts at RESET_PC after release; ack coincident with timeout -> no error.

Source files
------------

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared types and constants for the fetch slice
// Purpose: opcode constants, fetch FSM state encoding and default widths
//          used by the fetch unit, its bus interface and its sub-modules.
// Ports:   none (package).
package cpu_pkg;

  localparam int PC_W_DEF    = 8;
  localparam int INSTR_W_DEF = 16;

  localparam logic [3:0] OP_HALT = 4'b0000;
  localparam logic [3:0] OP_JMP  = 4'b0101;
  localparam logic [3:0] OP_BEQ  = 4'b0110;

  typedef enum logic [1:0] {
    REQ    = 2'd0,
    RETRY  = 2'd1,
    ISSUE  = 2'd2,
    HALTED = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// rtl/instr_fetch_unit_if.sv - imem request/ack bus and decode valid/ready bus
// Purpose: groups the instruction-memory handshake and the decode handshake.
// Ports (signals):
//   imem_req/imem_addr    fetch unit -> memory request and address
//   imem_ack/imem_rdata   memory -> fetch unit acknowledge and instruction word
//   instr_valid/instr     fetch unit -> decode instruction
//   instr_ready           decode -> fetch unit accept
// Modports: master = fetch unit side, slave = memory/decode side.
interface instr_fetch_unit_if
  import cpu_pkg::*;
#(
  parameter int PC_W    = PC_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF
);
  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;
  logic               instr_valid;
  logic [INSTR_W-1:0] instr;
  logic               instr_ready;

  modport master (
    output imem_req, imem_addr, instr_valid, instr,
    input  imem_ack, imem_rdata, instr_ready
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr,
    output imem_ack, imem_rdata, instr_ready
  );
endinterface

// File: rtl/fetch_timeout_ctr.sv
// rtl/fetch_timeout_ctr.sv - imem wait counter with terminal-count pulse
// Purpose: counts enabled cycles; tc_o pulses on the enabled cycle where the
//          count equals TIMEOUT-1, and the counter self-clears on that pulse.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   clr_i       synchronous clear (priority over enable)
//   en_i        count enable
//   tc_o        terminal-count pulse
module fetch_timeout_ctr #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  logic [7:0] cnt_q, cnt_d;

  assign tc_o = en_i && (cnt_q == 8'(TIMEOUT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i || tc_o) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - non-pipelined instruction fetch with PC register
// Purpose: holds the PC, fetches one instruction per step over imem req/ack,
//          presents it to decode over valid/ready, loads pc_next on accept,
//          retries after an imem timeout and stops on the halt opcode.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   pc_next     next PC from next-PC logic, sampled on accept
//   pc_now      current PC register
//   halted      sticky: halt instruction retired
//   fetch_err   sticky: at least one imem timeout
//   bus         master side of instr_fetch_unit_if (imem + decode handshakes)
module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter int              PC_W     = PC_W_DEF,
  parameter int              INSTR_W  = INSTR_W_DEF,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int              TIMEOUT  = 15,
  parameter logic [3:0]      HALT_OP  = OP_HALT
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [PC_W-1:0]     pc_next,
  output logic [PC_W-1:0]     pc_now,
  output logic                halted,
  output logic                fetch_err,
  instr_fetch_unit_if.master  bus
);

  fetch_state_t       state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic               err_q, err_d;
  // run_q keeps imem_req low while in reset and for the release cycle, so the
  // first request appears the cycle after the first clock edge out of reset.
  logic               run_q;
  logic               in_req;
  logic               ctr_clr, ctr_en, ctr_tc;
  logic [3:0]         opcode;

  assign in_req  = (state_q == REQ) && run_q;
  assign opcode  = instr_q[INSTR_W-1 -: 4];
  assign ctr_en  = in_req && !bus.imem_ack;
  assign ctr_clr = !in_req || bus.imem_ack;

  fetch_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout_ctr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (ctr_clr),
    .en_i  (ctr_en),
    .tc_o  (ctr_tc)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    err_d   = err_q;
    unique case (state_q)
      REQ: begin
        // ack beats timeout when both land on the same cycle
        if (in_req && bus.imem_ack) begin
          instr_d = bus.imem_rdata;
          state_d = ISSUE;
        end else if (ctr_tc) begin
          err_d   = 1'b1;
          state_d = RETRY;
        end
      end
      RETRY: begin
        state_d = REQ;
      end
      ISSUE: begin
        if (bus.instr_ready) begin
          pc_d    = pc_next;
          state_d = (opcode == HALT_OP) ? HALTED : REQ;
        end
      end
      HALTED: begin
        state_d = HALTED;
      end
      default: begin
        state_d = REQ;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= REQ;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      err_q   <= 1'b0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      err_q   <= err_d;
      run_q   <= 1'b1;
    end
  end

  assign pc_now          = pc_q;
  assign halted          = (state_q == HALTED);
  assign fetch_err       = err_q;
  assign bus.imem_req    = in_req;
  assign bus.imem_addr   = pc_q;
  assign bus.instr_valid = (state_q == ISSUE);
  assign bus.instr       = instr_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - directed self-checking bench for instr_fetch_unit
module tb_instr_fetch_unit;
  import cpu_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] pc_next = '0;
  logic [7:0] pc_now;
  logic       halted;
  logic       fetch_err;

  int n_checks = 0;
  int n_errors = 0;

  instr_fetch_unit_if #(.PC_W(8), .INSTR_W(16)) bus ();

  instr_fetch_unit #(
    .PC_W(8), .INSTR_W(16), .RESET_PC(8'h00), .TIMEOUT(15), .HALT_OP(OP_HALT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pc_next   (pc_next),
    .pc_now    (pc_now),
    .halted    (halted),
    .fetch_err (fetch_err),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_req"},   32'(bus.imem_req), 0);
    check({tag, "_valid"}, 32'(bus.instr_valid), 0);
    check({tag, "_instr"}, 32'(bus.instr), 0);
    check({tag, "_pc"},    32'(pc_now), 0);
    check({tag, "_halt"},  32'(halted), 0);
    check({tag, "_err"},   32'(fetch_err), 0);
  endtask

  task automatic wait_req();
    int n = 0;
    while (!bus.imem_req && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("req_seen", 32'(bus.imem_req), 1);
  endtask

  // One complete fetch/accept step: ack after lat extra request cycles.
  task automatic fetch(input logic [7:0] exp_addr, input logic [15:0] word,
                       input logic [7:0] nxt, input int lat);
    wait_req();
    check("addr", 32'(bus.imem_addr), 32'(exp_addr));
    for (int i = 0; i < lat; i++) begin
      @(negedge clk);
      check("req_hold", 32'(bus.imem_req), 1);
      check("addr_hold", 32'(bus.imem_addr), 32'(exp_addr));
    end
    bus.imem_ack = 1'b1;
    bus.imem_rdata = word;
    @(negedge clk);
    bus.imem_ack = 1'b0;
    bus.imem_rdata = 16'hdead;
    check("valid", 32'(bus.instr_valid), 1);
    check("instr", 32'(bus.instr), 32'(word));
    check("req_off", 32'(bus.imem_req), 0);
    bus.instr_ready = 1'b1;
    pc_next = nxt;
    @(negedge clk);
    bus.instr_ready = 1'b0;
    check("valid_drop", 32'(bus.instr_valid), 0);
    check("pc_load", 32'(pc_now), 32'(nxt));
  endtask

  initial begin
    bus.imem_ack = 1'b0;
    bus.imem_rdata = 16'h0;
    bus.instr_ready = 1'b0;

    repeat (2) @(negedge clk);
    check_reset_vals("rst");
    rst_n = 1'b1;

    // normal sequential fetches
    fetch(8'h00, 16'h1001, 8'h01, 1);
    fetch(8'h01, 16'h2002, 8'h02, 1);
    fetch(8'h02, 16'h3003, 8'h03, 0);

    // back-pressure
    wait_req();
    check("bp_addr", 32'(bus.imem_addr), 32'h03);
    bus.imem_ack = 1'b1;
    bus.imem_rdata = 16'h1234;
    @(negedge clk);
    bus.imem_ack = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", 32'(bus.instr_valid), 1);
      check("bp_instr", 32'(bus.instr), 32'h1234);
      check("bp_pc", 32'(pc_now), 32'h03);
      check("bp_req", 32'(bus.imem_req), 0);
      @(negedge clk);
    end
    bus.instr_ready = 1'b1;
    pc_next = 8'h10;
    @(negedge clk);
    bus.instr_ready = 1'b0;
    check("bp_pc_new", 32'(pc_now), 32'h10);

    // jump
    fetch(8'h10, 16'h5abc, 8'h40, 0);
    fetch(8'h40, 16'h6001, 8'h07, 2);

    // timeout at 0x07: 15 request cycles, one idle, then retry
    for (int k = 1; k <= 15; k++) begin
      check("to_req", 32'(bus.imem_req), 1);
      check("to_addr", 32'(bus.imem_addr), 32'h07);
      check("to_err_lo", 32'(fetch_err), 0);
      @(negedge clk);
    end
    check("to_gap_req", 32'(bus.imem_req), 0);
    check("to_err_hi", 32'(fetch_err), 1);
    @(negedge clk);
    check("to_retry_req", 32'(bus.imem_req), 1);
    check("to_retry_addr", 32'(bus.imem_addr), 32'h07);
    fetch(8'h07, 16'h7777, 8'h08, 0);
    check("err_sticky", 32'(fetch_err), 1);

    // halt: pc still loads pc_next on accept, then everything freezes
    fetch(8'h08, 16'h0000, 8'h33, 0);
    for (int i = 0; i < 20; i++) begin
      check("h_halted", 32'(halted), 1);
      check("h_req", 32'(bus.imem_req), 0);
      check("h_valid", 32'(bus.instr_valid), 0);
      check("h_pc", 32'(pc_now), 32'h33);
      bus.imem_ack = i[0];
      bus.imem_rdata = 16'h9999;
      bus.instr_ready = 1'b1;
      pc_next = 8'h55;
      @(negedge clk);
    end
    bus.imem_ack = 1'b0;
    bus.instr_ready = 1'b0;

    // reset from HALTED, then mid-REQ and mid-ISSUE
    rst_n = 1'b0;
    #1;
    check_reset_vals("rst_halt");
    @(negedge clk);
    rst_n = 1'b1;
    fetch(8'h00, 16'h1111, 8'h05, 1);
    wait_req();
    check("mr_addr", 32'(bus.imem_addr), 32'h05);
    rst_n = 1'b0;
    #1;
    check_reset_vals("rst_req");
    @(negedge clk);
    rst_n = 1'b1;
    wait_req();
    check("mi_addr", 32'(bus.imem_addr), 32'h00);
    bus.imem_ack = 1'b1;
    bus.imem_rdata = 16'h2abc;
    @(negedge clk);
    bus.imem_ack = 1'b0;
    check("mi_valid", 32'(bus.instr_valid), 1);
    rst_n = 1'b0;
    #1;
    check_reset_vals("rst_issue");
    @(negedge clk);
    rst_n = 1'b1;

    // ack on the terminal-count cycle wins
    wait_req();
    for (int k = 1; k <= 14; k++) begin
      check("co_req", 32'(bus.imem_req), 1);
      @(negedge clk);
    end
    check("co_req15", 32'(bus.imem_req), 1);
    bus.imem_ack = 1'b1;
    bus.imem_rdata = 16'h4444;
    @(negedge clk);
    bus.imem_ack = 1'b0;
    check("co_valid", 32'(bus.instr_valid), 1);
    check("co_instr", 32'(bus.instr), 32'h4444);
    check("co_err", 32'(fetch_err), 0);
    bus.instr_ready = 1'b1;
    pc_next = 8'h21;
    @(negedge clk);
    bus.instr_ready = 1'b0;
    check("co_pc", 32'(pc_now), 32'h21);
    check("co_err_after", 32'(fetch_err), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
